audio_fifo_reader: RTL and testbench

- Read-side consumer of the audio sample FIFO that the processor fills through the audio2fifo write port.
- Pops one 32-bit sample per sample period. The period is set by the processor-written divider value.
- Presents each sample to the audio codec path with a one-cycle valid strobe.
- Honours the processor's pause and stop controls and reports underflow events.

---
 rtl/audio_fifo_reader_if.sv | 27 ++
 rtl/audio_fifo_reader.sv | 115 +++++++++++
 tb/tb_audio_fifo_reader.sv | 281 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/audio_fifo_reader_if.sv
// FIFO read-side and codec-side signal bundle for the audio sample reader.
// master = the reader, slave = the FIFO/codec environment.
interface audio_fifo_reader_if #(
    parameter int DATA_W = 32
);
    logic [DATA_W-1:0] fifo_q;
    logic              fifo_empty;
    logic              fifo_rdreq;
    logic [DATA_W-1:0] audio_out;
    logic              sample_valid;

    modport master (
        input  fifo_q,
        input  fifo_empty,
        output fifo_rdreq,
        output audio_out,
        output sample_valid
    );

    modport slave (
        output fifo_q,
        output fifo_empty,
        input  fifo_rdreq,
        input  audio_out,
        input  sample_valid
    );
endinterface

// File: rtl/audio_fifo_reader.sv
// Audio FIFO read-side consumer: pops one sample per divider period, presents it
// to the codec path with a valid strobe, and handles pause, stop/flush and underflow.
module audio_fifo_reader #(
    parameter int DATA_W  = 32,
    parameter int DIV_W   = 32,
    parameter int MIN_DIV = 4,
    parameter int UFLOW_W = 16
) (
    input  logic               clk,
    input  logic               reset,
    audio_fifo_reader_if.master bus,
    input  logic [DIV_W-1:0]   div_freq,
    input  logic               pause,
    input  logic               stop,
    output logic               underflow,
    output logic [UFLOW_W-1:0] underflow_cnt,
    output logic               busy
);

    localparam logic [1:0] S_RUN   = 2'd0;
    localparam logic [1:0] S_FETCH = 2'd1;
    localparam logic [1:0] S_LATCH = 2'd2;
    localparam logic [1:0] S_FLUSH = 2'd3;

    logic [1:0]         state_q, state_d;
    logic [DIV_W-1:0]   cnt_q, cnt_d;
    logic               rdreq_q, rdreq_d;
    logic [DATA_W-1:0]  audio_q, audio_d;
    logic               valid_q, valid_d;
    logic               uflow_q, uflow_d;
    logic [UFLOW_W-1:0] ucnt_q, ucnt_d;

    logic [DIV_W-1:0]   period;
    logic               tick;

    // The >= compare lets a shorter period take effect without waiting for wrap.
    assign period = (div_freq < DIV_W'(MIN_DIV)) ? DIV_W'(MIN_DIV) : div_freq;
    assign tick   = (cnt_q >= period - DIV_W'(1));

    always_comb begin
        // NOTE: every output of this block gets a default first so no latch is inferred.
        state_d = state_q;
        cnt_d   = tick ? '0 : cnt_q + 1'b1;
        rdreq_d = 1'b0;
        audio_d = audio_q;
        valid_d = 1'b0;
        uflow_d = uflow_q;
        ucnt_d  = ucnt_q;

        case (state_q)
            S_RUN: begin
                if (stop) begin
                    state_d = S_FLUSH;
                    audio_d = '0;
                    uflow_d = 1'b0;
                    ucnt_d  = '0;
                end else if (tick && !pause) begin
                    if (!bus.fifo_empty) begin
                        rdreq_d = 1'b1;
                        state_d = S_FETCH;
                    end else begin
                        uflow_d = 1'b1;
                        if (ucnt_q != '1) ucnt_d = ucnt_q + 1'b1;
                    end
                end
            end
            S_FETCH: state_d = S_LATCH;
            S_LATCH: begin
                audio_d = bus.fifo_q;
                valid_d = 1'b1;
                state_d = S_RUN;
            end
            S_FLUSH: begin
                audio_d = '0;
                if (!stop && bus.fifo_empty) begin
                    state_d = S_RUN;
                    cnt_d   = '0;
                end else begin
                    // Registered, so one over-read can follow the cycle empty rises.
                    rdreq_d = !bus.fifo_empty;
                end
            end
            default: state_d = S_RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only.
        if (reset) begin
            state_q <= S_RUN;
            cnt_q   <= '0;
            rdreq_q <= 1'b0;
            audio_q <= '0;
            valid_q <= 1'b0;
            uflow_q <= 1'b0;
            ucnt_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rdreq_q <= rdreq_d;
            audio_q <= audio_d;
            valid_q <= valid_d;
            uflow_q <= uflow_d;
            ucnt_q  <= ucnt_d;
        end
    end

    assign bus.fifo_rdreq   = rdreq_q;
    assign bus.audio_out    = audio_q;
    assign bus.sample_valid = valid_q;
    assign underflow        = uflow_q;
    assign underflow_cnt    = ucnt_q;
    assign busy             = (state_q != S_RUN);

endmodule

// File: tb/tb_audio_fifo_reader.sv
// Directed bench for audio_fifo_reader with a behavioural normal-mode FIFO model.
module tb_audio_fifo_reader;

    localparam int DATA_W  = 32;
    localparam int DIV_W   = 32;
    localparam int UFLOW_W = 16;

    logic               clk;
    logic               reset;
    logic [DIV_W-1:0]   div_freq;
    logic               pause;
    logic               stop;
    logic               underflow;
    logic [UFLOW_W-1:0] underflow_cnt;
    logic               busy;

    audio_fifo_reader_if #(.DATA_W(DATA_W)) bus ();

    audio_fifo_reader #(
        .DATA_W (DATA_W),
        .DIV_W  (DIV_W),
        .MIN_DIV(4),
        .UFLOW_W(UFLOW_W)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .bus          (bus),
        .div_freq     (div_freq),
        .pause        (pause),
        .stop         (stop),
        .underflow    (underflow),
        .underflow_cnt(underflow_cnt),
        .busy         (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // FIFO model: word read on the edge ending an rdreq cycle, data valid after it.
    logic [DATA_W-1:0] mem [0:63];
    int wr_ptr    = 0;
    int rd_ptr    = 0;
    int overreads = 0;

    assign bus.fifo_empty = (wr_ptr == rd_ptr);

    always @(posedge clk) begin
        if (bus.fifo_rdreq === 1'b1) begin
            if (wr_ptr != rd_ptr) begin
                bus.fifo_q <= mem[rd_ptr];
                rd_ptr     <= rd_ptr + 1;
            end else begin
                overreads  <= overreads + 1;
            end
        end
    end

    int                cyc = 0;
    int                rd_cyc[$];
    int                sv_cyc[$];
    logic [DATA_W-1:0] sv_data[$];

    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (bus.fifo_rdreq === 1'b1) rd_cyc.push_back(cyc);
        if (bus.sample_valid === 1'b1) begin
            sv_cyc.push_back(cyc);
            sv_data.push_back(bus.audio_out);
        end
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic push(input logic [DATA_W-1:0] w);
        mem[wr_ptr] = w;
        wr_ptr++;
    endtask

    task automatic wait_sv(input int target, input int limit, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < limit && !ok; i++) begin
            step(1);
            if (sv_cyc.size() >= target) ok = 1'b1;
        end
    endtask

    task automatic wait_rd(input int target, input int limit, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < limit && !ok; i++) begin
            step(1);
            if (rd_cyc.size() >= target) ok = 1'b1;
        end
    endtask

    task automatic wait_ucnt_change(input int limit, output bit ok);
        logic [UFLOW_W-1:0] base;
        base = underflow_cnt;
        ok   = 1'b0;
        for (int i = 0; i < limit && !ok; i++) begin
            step(1);
            if (underflow_cnt != base) ok = 1'b1;
        end
    endtask

    task automatic wait_empty(input int limit, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < limit && !ok; i++) begin
            step(1);
            if (wr_ptr == rd_ptr) ok = 1'b1;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit                 ok;
        logic [UFLOW_W-1:0] ubase;
        logic [DATA_W-1:0]  abase;
        int                 rbase, sbase, obase;

        reset    = 1'b1;
        pause    = 1'b0;
        stop     = 1'b0;
        div_freq = 32'd10;
        push(32'h0001_0002);
        push(32'h0003_0004);
        step(3);
        check("rst_rdreq", bus.fifo_rdreq, 0);
        check("rst_audio", bus.audio_out, 0);
        check("rst_valid", bus.sample_valid, 0);
        check("rst_uflow", underflow, 0);
        check("rst_ucnt", underflow_cnt, 0);
        check("rst_busy", busy, 0);
        reset = 1'b0;

        // Two words at div 10: reads 10 cycles apart, sample 2 cycles after rdreq.
        wait_sv(2, 60, ok);
        check("run_wait_sv", ok, 1);
        check("run_rd_count", rd_cyc.size(), 2);
        check("run_rd_spacing", rd_cyc[1] - rd_cyc[0], 10);
        check("run_lat0", sv_cyc[0] - rd_cyc[0], 2);
        check("run_lat1", sv_cyc[1] - rd_cyc[1], 2);
        check("run_data0", sv_data[0], 32'h0001_0002);
        check("run_data1", sv_data[1], 32'h0003_0004);
        check("run_no_uflow", underflow, 0);
        step(1);
        check("run_valid_width", bus.sample_valid, 0);

        // Drained FIFO at div 8: starved ticks count up 8 cycles apart.
        div_freq = 32'd8;
        wait_ucnt_change(30, ok);
        check("uf_wait", ok, 1);
        check("uf_sticky", underflow, 1);
        check("uf_cnt1", underflow_cnt, 1);
        check("uf_audio_hold", bus.audio_out, 32'h0003_0004);
        step(23);
        check("uf_cnt3", underflow_cnt, 3);
        step(1);
        check("uf_cnt4", underflow_cnt, 4);

        // Clamped periods: div 0 and div 2 both give 4 cycles.
        div_freq = 32'd0;
        wait_ucnt_change(20, ok);
        wait_ucnt_change(20, ok);
        check("clamp0_sync", ok, 1);
        ubase = underflow_cnt;
        step(3);
        check("clamp0_hold", underflow_cnt, ubase);
        step(1);
        check("clamp0_tick", underflow_cnt, ubase + 1'b1);
        div_freq = 32'd2;
        wait_ucnt_change(20, ok);
        wait_ucnt_change(20, ok);
        check("clamp2_sync", ok, 1);
        ubase = underflow_cnt;
        step(3);
        check("clamp2_hold", underflow_cnt, ubase);
        step(1);
        check("clamp2_tick", underflow_cnt, ubase + 1'b1);

        // div 100 -> 6 while the counter is at 50: immediate tick, then every 6.
        div_freq = 32'd100;
        wait_ucnt_change(120, ok);
        check("div100_sync", ok, 1);
        ubase = underflow_cnt;
        step(50);
        div_freq = 32'd6;
        check("div_change_pre", underflow_cnt, ubase);
        step(1);
        check("div_change_tick", underflow_cnt, ubase + 1'b1);
        step(5);
        check("div6_hold", underflow_cnt, ubase + 1'b1);
        step(1);
        check("div6_tick", underflow_cnt, ubase + 2'd2);

        // Pause for three periods with five words queued.
        div_freq = 32'd10;
        pause    = 1'b1;
        for (int i = 1; i <= 5; i++) push(32'hA000_0000 + 32'(i));
        rbase = rd_cyc.size();
        abase = bus.audio_out;
        ubase = underflow_cnt;
        step(30);
        check("pause_no_rd", rd_cyc.size(), rbase);
        check("pause_audio", bus.audio_out, abase);
        check("pause_no_uf", underflow_cnt, ubase);
        pause = 1'b0;
        sbase = sv_cyc.size();
        wait_sv(sbase + 1, 20, ok);
        check("unpause_wait", ok, 1);
        check("unpause_word1", bus.audio_out, 32'hA000_0001);
        check("unpause_one_rd", rd_cyc.size(), rbase + 1);

        // Stop in the FETCH cycle with 20 words queued.
        for (int i = 6; i <= 21; i++) push(32'hA000_0000 + 32'(i));
        wait_rd(rd_cyc.size() + 1, 20, ok);
        check("stop_fetch_wait", ok, 1);
        stop  = 1'b1;
        obase = overreads;
        sbase = sv_cyc.size();
        wait_sv(sbase + 1, 5, ok);
        check("stop_inflight", ok, 1);
        check("stop_word2", bus.audio_out, 32'hA000_0002);
        wait_empty(60, ok);
        check("flush_drain", ok, 1);
        step(3);
        check("flush_pops", rd_ptr, 23);
        check("flush_audio", bus.audio_out, 0);
        check("flush_uflow", underflow, 0);
        check("flush_ucnt", underflow_cnt, 0);
        check("flush_busy", busy, 1);
        check("flush_no_valid", sv_cyc.size(), sbase + 1);
        check("flush_overread", (overreads - obase) <= 1, 1);
        stop = 1'b0;
        step(2);
        check("flush_exit_busy", busy, 0);
        check("flush_exit_rdreq", bus.fifo_rdreq, 0);

        // Reset asserted in the LATCH cycle.
        wait_ucnt_change(30, ok);
        check("pre_reset_uf", underflow, 1);
        push(32'hDEAD_BEEF);
        wait_rd(rd_cyc.size() + 1, 20, ok);
        check("pre_reset_fetch", ok, 1);
        step(1);
        reset = 1'b1;
        step(1);
        check("latch_rst_audio", bus.audio_out, 0);
        check("latch_rst_rdreq", bus.fifo_rdreq, 0);
        check("latch_rst_valid", bus.sample_valid, 0);
        check("latch_rst_busy", busy, 0);
        check("latch_rst_ucnt", underflow_cnt, 0);
        check("latch_rst_uflow", underflow, 0);
        reset = 1'b0;
        step(1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
